grf_write_arbiter: RTL and testbench
====================================

// Module: grf_write_arbiter
// PURPOSE
// Sole writer of the general register file. Merges main-pipeline writebacks with results
// from the multi-cycle mult/div unit (MDU) onto the single GRF write port (A3/WD_RF/PC/RegWrite).
// Buffers MDU results in a FIFO and publishes a busy mask for hazard detection.
// Requests a pipeline stall when buffered results are starved.
// PARAMETERS
// DEPTH       4   MDU result FIFO entries (power of two, >=2)
// STARVE_MAX  8   consecutive blocked cycles before stall_req asserts (>=1)
// PORTS
// CLK        in   1   clock, all state on posedge
// Reset      in   1   synchronous, active-high
// wb_en      in   1   pipeline writeback valid this cycle
// wb_addr    in   5   pipeline destination register
// wb_data    in   32  pipeline write data
// wb_pc      in   32  PC of the writing instruction
// mdu_valid  in   1   MDU result valid
// mdu_ready  out  1   = !fifo_full; transfer when mdu_valid & mdu_ready
// mdu_addr   in   5   MDU destination register
// mdu_data   in   32  MDU result
// mdu_pc     in   32  PC of the MDU instruction
// A3         out  5   GRF write address (registered)
// WD_RF      out  32  GRF write data (registered)
// PC         out  32  PC forwarded to GRF for write trace (registered)
// RegWrite   out  1   GRF write enable (registered)
// busy_mask  out  32  bit r = 1 while any FIFO entry or output register targets r; bit 0 always 0
// stall_req  out  1   pipeline must hold wb_en low while 1 (registered)
// BEHAVIOUR
// - Reset: A3=0, WD_RF=0, PC=0, RegWrite=0, stall_req=0, FIFO emptied, busy_mask=0,
//   starve counter=0, state IDLE. Reset mid-operation discards all buffered results.
// - Latency: request in cycle N -> GRF write signals valid in cycle N+1 (one register stage).
// - Per cycle exactly one source drives the output register:
//   wb_en=1 & wb_addr!=0 -> pipeline (priority); else FIFO non-empty -> pop head; else RegWrite=0.
// - wb_en=1 with wb_addr=0: no write, does NOT block FIFO drain that cycle.
// - MDU enqueue when mdu_valid & mdu_ready; mdu_addr=0 handshakes but is dropped (not enqueued).
// - Full FIFO: mdu_ready=0 even if a pop happens the same cycle (no bypass-on-full).
// - Empty FIFO + MDU arrival + no pipeline write: still enqueued, written next cycle (no bypass).
// - Simultaneous push and pop when not full: both occur, count unchanged; FIFO order preserved.
// - Same-register conflict pipeline vs FIFO head: pipeline wins, head written later (later value
//   overwrites). Ordering is issuer's responsibility via busy_mask; no reordering here.
// - busy_mask is combinational from FIFO entries plus output register (RegWrite & A3).
// - FSM: IDLE   (FIFO empty)                       -> DRAIN on enqueue
//        DRAIN  (non-empty, counter counts blocked cycles) -> IDLE when emptied;
//               -> STARVED when counter reaches STARVE_MAX
//        STARVED (stall_req=1)                     -> IDLE when FIFO empties, counter cleared
// - Blocked cycle = FIFO non-empty and pipeline wins the port. Counter resets on every pop.
// - stall_req stays 1 until FIFO empty; if pipeline writes anyway while stalled, pipeline still wins.
// - Counter saturates at STARVE_MAX; pointers wrap modulo DEPTH.
// TESTING
// 1 Reset 3 cycles -> RegWrite=0, A3=0, WD_RF=0, PC=0, busy_mask=0, stall_req=0, mdu_ready=1.
// 2 wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF, wb_pc=32'h3000 -> next cycle RegWrite=1, A3=5,
//   WD_RF=32'hDEADBEEF, PC=32'h3000; busy_mask[5]=1 for that one cycle only.
// 3 MDU pushes r8=1,r9=2,r10=3,r11=4 back-to-back, wb_en=1 (r2) held -> mdu_ready=0 after 4th,
//   busy_mask bits 8..11 =1; release wb_en -> writes r8,r9,r10,r11 in order over 4 cycles.
// 4 One MDU entry r7, wb_en=1 to r3 for 8 cycles -> stall_req=1 on cycle 9; drop wb_en ->
//   r7 written next cycle, stall_req=0 cycle after, state IDLE.
// 5 mdu_addr=0 push and wb_addr=0 write with FIFO holding r4 -> no r0 write, r4 written next cycle.
// 6 Reset asserted with 3 entries queued -> next cycle FIFO empty, busy_mask=0, no further writes.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: single writer of the GRF write port.
// Merges pipeline writebacks with buffered MDU results.
module grf_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    output logic [4:0]  A3,
    output logic [31:0] WD_RF,
    output logic [31:0] PC,
    output logic        RegWrite,
    output logic [31:0] busy_mask,
    output logic        stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_STARVED = 2'd2;

    logic [4:0]       r_fifo_addr [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [SW-1:0]    r_starve;
    logic [1:0]       r_state;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd;
    logic [31:0]      r_pc;
    logic             r_we;
    logic             r_stall;

    logic             w_full;
    logic             w_empty;
    logic             w_wb_win;
    logic             w_handshake;
    logic             w_push;
    logic             w_pop;
    logic             w_blocked;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SW-1:0]    w_starve_nxt;
    logic [1:0]       w_state_nxt;
    logic [31:0]      w_busy;
    logic [PTR_W-1:0] w_offs;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign mdu_ready   = !w_full;
    assign w_wb_win    = wb_en && (wb_addr != 5'd0);
    assign w_handshake = mdu_valid && mdu_ready;
    assign w_push      = w_handshake && (mdu_addr != 5'd0);
    assign w_pop       = !w_wb_win && !w_empty;
    assign w_blocked   = w_wb_win && !w_empty;

    assign A3        = r_a3;
    assign WD_RF     = r_wd;
    assign PC        = r_pc;
    assign RegWrite  = r_we;
    assign stall_req = r_stall;
    assign busy_mask = w_busy;

    // Next occupancy from push/pop of this cycle.
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Starvation counter and drain-state transitions.
    always_comb begin
        w_starve_nxt = r_starve;
        w_state_nxt  = r_state;
        if (w_pop) begin
            w_starve_nxt = '0;
        end else if (w_blocked && (r_starve != SW'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + SW'(1);
        end
        case (r_state)
            S_IDLE: begin
                if (w_cnt_nxt != '0)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_cnt_nxt == '0)
                    w_state_nxt = S_IDLE;
                else if (w_starve_nxt == SW'(STARVE_MAX))
                    w_state_nxt = S_STARVED;
            end
            S_STARVED: begin
                if (w_cnt_nxt == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_IDLE)
            w_starve_nxt = '0;
    end

    // Busy registers: live FIFO entries plus the pending output write.
    always_comb begin
        w_busy = '0;
        w_offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offs = PTR_W'(i) - r_rptr;
            if ({1'b0, w_offs} < r_count)
                w_busy[r_fifo_addr[i]] = 1'b1;
        end
        if (r_we)
            w_busy[r_a3] = 1'b1;
        w_busy[0] = 1'b0;
    end

    // FIFO storage; contents need no reset since pointers are cleared.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= mdu_addr;
            r_fifo_data[r_wptr] <= mdu_data;
            r_fifo_pc[r_wptr]   <= mdu_pc;
        end
    end

    // FIFO pointers, occupancy, FSM and stall request.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_state  <= S_IDLE;
            r_stall  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count  <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            r_state  <= w_state_nxt;
            r_stall  <= (w_state_nxt == S_STARVED);
        end
    end

    // Output register: pipeline first, then FIFO head, else idle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_a3 <= 5'd0;
            r_wd <= 32'd0;
            r_pc <= 32'd0;
            r_we <= 1'b0;
        end else if (w_wb_win) begin
            r_a3 <= wb_addr;
            r_wd <= wb_data;
            r_pc <= wb_pc;
            r_we <= 1'b1;
        end else if (w_pop) begin
            r_a3 <= r_fifo_addr[r_rptr];
            r_wd <= r_fifo_data[r_rptr];
            r_pc <= r_fifo_pc[r_rptr];
            r_we <= 1'b1;
        end else begin
            r_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: directed vectors plus multi-cycle
// sequences for FIFO drain, starvation and reset.
module tb_grf_write_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic [4:0]  A3;
    logic [31:0] WD_RF;
    logic [31:0] PC;
    logic        RegWrite;
    logic [31:0] busy_mask;
    logic        stall_req;

    int n_chk = 0;
    int n_fail = 0;

    grf_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_pc(wb_pc),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_pc(mdu_pc),
        .A3(A3), .WD_RF(WD_RF), .PC(PC),
        .RegWrite(RegWrite), .busy_mask(busy_mask),
        .stall_req(stall_req)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] wb_pc;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
        logic [31:0] exp_pc;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        wb_pc     = 32'd0;
        mdu_valid = 1'b0;
        mdu_addr  = 5'd0;
        mdu_data  = 32'd0;
        mdu_pc    = 32'd0;
    endtask

    task automatic set_wb(input logic [4:0] a,
                          input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        wb_pc   = 32'h1000 + {27'd0, a};
    endtask

    task automatic set_mdu(input logic [4:0] a,
                           input logic [31:0] d);
        mdu_valid = 1'b1;
        mdu_addr  = a;
        mdu_data  = d;
        mdu_pc    = 32'h2000 + {27'd0, a};
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h3000,
                    1'b1, 5'd5, 32'hDEADBEEF, 32'h3000,
                    32'h0000_0020};
        vecs[1] = '{1'b0, 5'd5, 32'h0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0,
                    32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'h1234_5678, 32'h3004,
                    1'b0, 5'd0, 32'h0, 32'h0,
                    32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 32'h3008,
                    1'b1, 5'd31, 32'hA5A5_5A5A, 32'h3008,
                    32'h8000_0000};
        vecs[4] = '{1'b1, 5'd1, 32'h0000_0001, 32'h300C,
                    1'b1, 5'd1, 32'h0000_0001, 32'h300C,
                    32'h0000_0002};
        vecs[5] = '{1'b0, 5'd1, 32'h0, 32'h0,
                    1'b0, 5'd0, 32'h0, 32'h0,
                    32'h0};

        idle_inputs();
        Reset = 1'b1;
        repeat (3) step();
        chk("rst_we", {31'd0, RegWrite}, 32'd0);
        chk("rst_a3", {27'd0, A3}, 32'd0);
        chk("rst_wd", WD_RF, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_ready", {31'd0, mdu_ready}, 32'd1);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            wb_en   = vecs[i].wb_en;
            wb_addr = vecs[i].wb_addr;
            wb_data = vecs[i].wb_data;
            wb_pc   = vecs[i].wb_pc;
            step();
            chk($sformatf("vec%0d_we", i),
                {31'd0, RegWrite}, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_a3", i),
                    {27'd0, A3}, {27'd0, vecs[i].exp_a3});
                chk($sformatf("vec%0d_wd", i),
                    WD_RF, vecs[i].exp_wd);
                chk($sformatf("vec%0d_pc", i),
                    PC, vecs[i].exp_pc);
            end
            chk($sformatf("vec%0d_busy", i),
                busy_mask, vecs[i].exp_busy);
        end
        idle_inputs();
        step();

        // Fill FIFO while the pipeline owns the port.
        set_wb(5'd2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            set_mdu(5'(8 + i), 32'(i + 1));
            step();
        end
        mdu_valid = 1'b0;
        chk("full_ready", {31'd0, mdu_ready}, 32'd0);
        chk("full_busy", busy_mask, 32'h0000_0F04);
        chk("full_a3", {27'd0, A3}, 32'd2);
        wb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("drain%0d_we", i),
                {31'd0, RegWrite}, 32'd1);
            chk($sformatf("drain%0d_a3", i),
                {27'd0, A3}, 32'(8 + i));
            chk($sformatf("drain%0d_wd", i),
                WD_RF, 32'(i + 1));
            chk($sformatf("drain%0d_pc", i),
                PC, 32'h2008 + 32'(i));
        end
        chk("drain_ready", {31'd0, mdu_ready}, 32'd1);
        step();
        chk("drain_end_we", {31'd0, RegWrite}, 32'd0);
        chk("drain_end_busy", busy_mask, 32'd0);

        // Empty FIFO, MDU arrival, no bypass.
        set_mdu(5'd6, 32'h66);
        step();
        mdu_valid = 1'b0;
        chk("nobyp_we", {31'd0, RegWrite}, 32'd0);
        chk("nobyp_busy", busy_mask, 32'h0000_0040);
        step();
        chk("nobyp_we2", {31'd0, RegWrite}, 32'd1);
        chk("nobyp_a3", {27'd0, A3}, 32'd6);
        chk("nobyp_wd", WD_RF, 32'h66);
        step();

        // Starvation: one entry blocked for 8 cycles.
        set_wb(5'd3, 32'h33);
        set_mdu(5'd7, 32'h77);
        step();
        mdu_valid = 1'b0;
        repeat (7) step();
        chk("starve7", {31'd0, stall_req}, 32'd0);
        step();
        chk("starve8", {31'd0, stall_req}, 32'd1);
        chk("starve_a3", {27'd0, A3}, 32'd3);
        wb_en = 1'b0;
        step();
        chk("unstarve_we", {31'd0, RegWrite}, 32'd1);
        chk("unstarve_a3", {27'd0, A3}, 32'd7);
        chk("unstarve_wd", WD_RF, 32'h77);
        step();
        chk("unstarve_stall", {31'd0, stall_req}, 32'd0);
        chk("unstarve_we2", {31'd0, RegWrite}, 32'd0);

        // r0 traffic does not block or enqueue.
        set_wb(5'd3, 32'h33);
        set_mdu(5'd4, 32'h44);
        step();
        wb_addr  = 5'd0;
        mdu_addr = 5'd0;
        mdu_data = 32'hBAD;
        step();
        idle_inputs();
        chk("r0_we", {31'd0, RegWrite}, 32'd1);
        chk("r0_a3", {27'd0, A3}, 32'd4);
        chk("r0_wd", WD_RF, 32'h44);
        chk("r0_busy", busy_mask, 32'h0000_0010);
        step();
        chk("r0_we2", {31'd0, RegWrite}, 32'd0);
        chk("r0_busy2", busy_mask, 32'd0);

        // Reset discards queued entries.
        set_wb(5'd3, 32'h33);
        for (int i = 0; i < 3; i++) begin
            set_mdu(5'(12 + i), 32'(i));
            step();
        end
        idle_inputs();
        chk("prerst_busy", busy_mask, 32'h0000_7008);
        Reset = 1'b1;
        step();
        chk("midrst_busy", busy_mask, 32'd0);
        chk("midrst_we", {31'd0, RegWrite}, 32'd0);
        chk("midrst_ready", {31'd0, mdu_ready}, 32'd1);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("postrst%0d_we", i),
                {31'd0, RegWrite}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
